// File: rtl/ex_wb_buffer.sv
// Two-entry elastic buffer between the execute-stage result and register-file write-back.
// It also gives execute a combinational forwarding lookup over results that are held but not yet written.
module ex_wb_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_regwrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_regwrite,
  input  logic [ADDR_W-1:0] fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
  } entry_t;

  state_t state, state_nxt;
  logic   armed;
  entry_t older, younger, in_entry;
  logic   push, pop;
  logic   hit_older, hit_younger;

  assign in_entry = '{result: in_result, rd: in_rd, regwrite: in_regwrite};
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // armed holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      armed <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default first so that no path through the case infers a latch.
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: entry storage has no reset; every reader is gated by state, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (!flush) begin
      case (state)
        EMPTY: if (push) older <= in_entry;
        ONE: begin
          if (push && pop) older   <= in_entry;
          else if (push)   younger <= in_entry;
        end
        FULL:    if (pop) older <= younger;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready     = armed && (state != FULL);
    out_valid    = (state != EMPTY);
    count        = state;
    out_result   = '0;
    out_rd       = '0;
    out_regwrite = 1'b0;
    if (state != EMPTY) begin
      out_result   = older.result;
      out_rd       = older.rd;
      out_regwrite = older.regwrite;
    end
  end

  // The younger entry exists only when FULL and takes precedence as the most recent producer.
  always_comb begin
    hit_older   = (state != EMPTY) && older.regwrite && (older.rd == fwd_rd);
    hit_younger = (state == FULL) && younger.regwrite && (younger.rd == fwd_rd);
    fwd_hit     = hit_older || hit_younger;
    fwd_data    = '0;
    if (hit_younger)    fwd_data = younger.result;
    else if (hit_older) fwd_data = older.result;
  end

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Testbench for ex_wb_buffer: directed vector table plus hand-written reset and stall sequences.
module tb_ex_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_regwrite, flush;
  logic [15:0] in_result;
  logic [1:0]  in_rd;
  logic        out_valid, out_ready, out_regwrite;
  logic [15:0] out_result;
  logic [1:0]  out_rd;
  logic [1:0]  fwd_rd;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ex_wb_buffer #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  typedef struct {
    logic        iv;
    logic [15:0] ires;
    logic [1:0]  ird;
    logic        irw;
    logic        fl;
    logic        ordy;
    logic [1:0]  frd;
    logic [1:0]  e_cnt;
    logic        e_ov;
    logic [15:0] e_res;
    logic [1:0]  e_rd;
    logic        e_rw;
    logic        e_rdy;
    logic        e_hit;
    logic [15:0] e_fdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] res, input logic [1:0] rd,
                       input logic rw, input logic fl, input logic ordy, input logic [1:0] frd);
    in_valid = iv; in_result = res; in_rd = rd; in_regwrite = rw;
    flush = fl; out_ready = ordy; fwd_rd = frd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".count"},     32'(count),        32'd0);
    check({tag, ".out_valid"}, 32'(out_valid),    32'd0);
    check({tag, ".out_result"},32'(out_result),   32'd0);
    check({tag, ".out_rd"},    32'(out_rd),       32'd0);
    check({tag, ".out_rw"},    32'(out_regwrite), 32'd0);
    check({tag, ".fwd_hit"},   32'(fwd_hit),      32'd0);
    check({tag, ".fwd_data"},  32'(fwd_data),     32'd0);
    check({tag, ".in_ready"},  32'(in_ready),     32'd0);
  endtask

  initial begin
    // Field order: iv, ires, ird, irw, fl, ordy, frd | cnt, ov, res, rd, rw, rdy, hit, fdata
    vecs[0]  = '{0, 16'h0000, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000}; // first edge: ready rises
    vecs[1]  = '{1, 16'hF000, 1, 1, 0, 0, 1,  1, 1, 16'hF000, 1, 1, 1, 1, 16'hF000};
    vecs[2]  = '{1, 16'hFFF8, 2, 1, 0, 0, 2,  2, 1, 16'hF000, 1, 1, 0, 1, 16'hFFF8};
    vecs[3]  = '{1, 16'h1234, 3, 1, 0, 1, 3,  1, 1, 16'hFFF8, 2, 1, 1, 0, 16'h0000}; // 1234 refused
    vecs[4]  = '{0, 16'h0000, 0, 0, 0, 1, 2,  0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000};
    vecs[5]  = '{1, 16'h0001, 0, 1, 0, 0, 0,  1, 1, 16'h0001, 0, 1, 1, 1, 16'h0001};
    vecs[6]  = '{1, 16'h8000, 1, 0, 0, 1, 1,  1, 1, 16'h8000, 1, 0, 1, 0, 16'h0000}; // push+pop in ONE
    vecs[7]  = '{0, 16'h0000, 0, 0, 0, 1, 1,  0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000};
    vecs[8]  = '{1, 16'h0011, 3, 1, 0, 0, 3,  1, 1, 16'h0011, 3, 1, 1, 1, 16'h0011};
    vecs[9]  = '{1, 16'h0022, 3, 1, 0, 0, 3,  2, 1, 16'h0011, 3, 1, 0, 1, 16'h0022}; // youngest wins
    vecs[10] = '{0, 16'h0000, 0, 0, 0, 0, 0,  2, 1, 16'h0011, 3, 1, 0, 0, 16'h0000};
    vecs[11] = '{1, 16'h0055, 0, 1, 1, 1, 0,  0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000}; // flush drops push
    vecs[12] = '{1, 16'h0011, 3, 1, 0, 0, 3,  1, 1, 16'h0011, 3, 1, 1, 1, 16'h0011};
    vecs[13] = '{1, 16'h0022, 3, 0, 0, 0, 3,  2, 1, 16'h0011, 3, 1, 0, 1, 16'h0011}; // younger rw=0
    vecs[14] = '{0, 16'h0000, 0, 0, 0, 1, 3,  1, 1, 16'h0022, 3, 0, 1, 0, 16'h0000};
    vecs[15] = '{0, 16'h0000, 0, 0, 0, 1, 3,  0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000};
    vecs[16] = '{1, 16'hABCD, 2, 1, 0, 0, 2,  1, 1, 16'hABCD, 2, 1, 1, 1, 16'hABCD};
    vecs[17] = '{1, 16'h5A5A, 2, 1, 0, 0, 2,  2, 1, 16'hABCD, 2, 1, 0, 1, 16'h5A5A};

    rst_n = 1'b0;
    drive(0, 16'h0000, 0, 0, 0, 0, 0);
    #2;
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pre_edge.in_ready", 32'(in_ready), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].ires, vecs[i].ird, vecs[i].irw,
            vecs[i].fl, vecs[i].ordy, vecs[i].frd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.count", i),      32'(count),        32'(vecs[i].e_cnt));
      check($sformatf("v%0d.out_valid", i),  32'(out_valid),    32'(vecs[i].e_ov));
      check($sformatf("v%0d.out_result", i), 32'(out_result),   32'(vecs[i].e_res));
      check($sformatf("v%0d.out_rd", i),     32'(out_rd),       32'(vecs[i].e_rd));
      check($sformatf("v%0d.out_rw", i),     32'(out_regwrite), 32'(vecs[i].e_rw));
      check($sformatf("v%0d.in_ready", i),   32'(in_ready),     32'(vecs[i].e_rdy));
      check($sformatf("v%0d.fwd_hit", i),    32'(fwd_hit),      32'(vecs[i].e_hit));
      check($sformatf("v%0d.fwd_data", i),   32'(fwd_data),     32'(vecs[i].e_fdata));
    end

    // Stall while FULL: held data must not move and the offered word must not enter.
    drive(1, 16'h7777, 1, 1, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d.count", c),      32'(count),      32'd2);
      check($sformatf("stall%0d.out_result", c), 32'(out_result), 32'hABCD);
      check($sformatf("stall%0d.out_rd", c),     32'(out_rd),     32'd2);
      check($sformatf("stall%0d.fwd_hit", c),    32'(fwd_hit),    32'd0);
    end

    // Asynchronous reset in the middle of a cycle with count=2.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    drive(0, 16'h0000, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_reset_pre_edge.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post_reset.in_ready",  32'(in_ready),  32'd1);
    check("post_reset.count",     32'(count),     32'd0);
    check("post_reset.out_valid", 32'(out_valid), 32'd0);

    // Buffer still works after the reset pulse.
    drive(1, 16'h0F0F, 1, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    check("after_reset.out_result", 32'(out_result), 32'h0F0F);
    check("after_reset.fwd_data",   32'(fwd_data),   32'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_wb_buffer.md
Name: ex_wb_buffer

Overview:
- Two-entry elastic buffer between the execute-stage shift/ALU result (e.g. the arithmetic-right-shift output) and the register-file write-back port of the 16-bit CPU.
- Decouples execute from write-back using valid/ready handshakes.
- Gives execute a combinational forwarding lookup over pending, not-yet-written results.

Parameters:
DATA_W, 16, width of the result word (rd data)
ADDR_W, 2, width of the destination register index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute presents a result
in_ready  output  1  buffer can accept a result this cycle
in_result  input  DATA_W  result word from execute (shifter/ALU output)
in_rd  input  ADDR_W  destination register index
in_regwrite  input  1  result must be written to the register file
flush  input  1  discard all held entries (branch/exception squash)
out_valid  output  1  oldest entry available to write-back
out_ready  input  1  write-back consumes the oldest entry this cycle
out_result  output  DATA_W  oldest entry data
out_rd  output  ADDR_W  oldest entry destination
out_regwrite  output  1  oldest entry write enable
fwd_rd  input  ADDR_W  register index queried by execute
fwd_hit  output  1  a held entry with regwrite=1 targets fwd_rd
fwd_data  output  DATA_W  data of the youngest matching entry
count  output  2  number of held entries (0..2)

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low on rst_n. Asserting rst_n=0 at any time, including mid-transfer, immediately sets count=0, out_valid=0, out_result=0, out_rd=0, out_regwrite=0, fwd_hit=0, fwd_data=0 and in_ready=0. in_ready goes to 1 on the first rising clk edge after rst_n deasserts.
- State machine: EMPTY (count=0), ONE (count=1), FULL (count=2).
- Transfer conditions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL). It is a registered-state decode and never depends on out_ready, so there is no combinational ready path.
- out_valid = (state != EMPTY).
- Output values: out_result, out_rd and out_regwrite show the oldest entry. When EMPTY they are driven to 0.
- Latency: a pushed entry appears on the outputs on the next rising edge. There is no same-cycle bypass.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE. On push & pop the new entry becomes oldest and data is continuous.
  - FULL: pop -> ONE and the younger entry becomes oldest. Push is impossible because in_ready=0.
- flush: highest priority. On the next edge state -> EMPTY. Any push and any pop in the same cycle are discarded. Write-back must not act on a pop in a flush cycle.
- Forwarding lookup (combinational):
  - Compare fwd_rd against held entries with regwrite=1.
  - If both entries match, the youngest wins.
  - On no match, fwd_hit=0 and fwd_data=0.
  - Entries with regwrite=0 never hit.
  - The entry being pushed this cycle is not searched.
- Data width: data is stored unchanged. No sign or width manipulation.
- Held data: entries are stored as full records (result, rd, regwrite). Held data must not change while out_valid=1 & out_ready=0.
- count equals the number of held entries at all times.

Test Plan:
- Reset then idle -> count=0, out_valid=0, out_result=0x0000, in_ready=1 after the first edge. Pulse rst_n low mid-operation with count=2 -> all outputs 0 immediately.
- Push {0xF000, rd=1, rw=1} with out_ready=0 -> next cycle out_valid=1, out_result=0xF000, out_rd=1, count=1. Push {0xFFF8, rd=2, rw=1} -> count=2, in_ready=0, out_result still 0xF000.
- From FULL, hold in_valid=1 with new data 0x1234 and out_ready=1 for one cycle -> 0xF000 popped, 0x1234 not accepted, out_result=0xFFF8, count=1.
- In ONE holding 0x0001, do push {0x8000} and pop in the same cycle -> count stays 1, out_result=0x8000 next cycle.
- Forwarding priority: held entries {0x0011, rd=3, rw=1} (older) and {0x0022, rd=3, rw=1} (younger), fwd_rd=3 -> fwd_hit=1, fwd_data=0x0022. Change the younger entry to rw=0 -> fwd_data=0x0011. With fwd_rd=0 -> fwd_hit=0, fwd_data=0.
- flush with count=2 while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, fwd_hit=0, and the pushed entry is absent.
